local_port_ni: RTL and testbench
================================

# local_port_ni

Network interface for the router's local port: it buffers core-generated flits and injects them into the router's parallel local input (`rx_data_l`/`rx_valid_l`/local busy), and it accepts flits the router ejects on `tx_data_l`/`tx_valid_l`, applying `tx_busy[LOCAL]` backpressure. It sits between a processing element (or traffic generator) and one router, in that router's clock domain. It also provides traffic counters, a sticky misroute flag and a stall watchdog.

## Interface
- `ADDR_SZ`, 4, address field width
- `PL_SZ`, 16, payload field width
- `HDR_SZ`, 2, header field width; `FLIT_W = HDR_SZ+PL_SZ+ADDR_SZ`
- `INJ_DEPTH`, 4, injection FIFO depth (power of 2, ≥2)
- `EJ_DEPTH`, 4, ejection FIFO depth (power of 2, ≥2)
- `STALL_MAX`, 255, injection stall threshold in cycles
- `clk` in 1: router clock
- `reset` in 1: asynchronous, active-high
- `id` in ADDR_SZ: this node's address
- `inj_valid` in 1: core offers a flit
- `inj_data` in FLIT_W: core flit
- `inj_ready` out 1: injection FIFO not full
- `net_rx_data` out FLIT_W: to router `rx_data_l`
- `net_rx_valid` out 1: to router `rx_valid_l`
- `net_rx_busy` in 1: router local-input FIFO full (`rx_busy[LOCAL]`)
- `net_tx_data` in FLIT_W: from router `tx_data_l`
- `net_tx_valid` in 1: from router `tx_valid_l`
- `net_tx_busy` out 1: to router `tx_busy[LOCAL]`
- `ej_valid` out 1: ejected flit available
- `ej_data` out FLIT_W: ejected flit
- `ej_ready` in 1: core consumes flit
- `sent_count` out 16: flits injected into router
- `recv_count` out 16: flits accepted from router
- `misroute` out 1: sticky, flit received with wrong address
- `stall` out 1: sticky, injection blocked ≥ STALL_MAX cycles

## Operation
- Flit layout: `[ADDR_SZ-1:0]` destination, `[ADDR_SZ+PL_SZ-1:ADDR_SZ]` payload, top HDR_SZ bits header.
- Core push: on edge with `inj_valid && inj_ready`. `inj_ready = !inj_full`.
- Injection: `net_rx_valid = !inj_empty`, `net_rx_data` = FIFO head (show-ahead). Transfer on edge with `net_rx_valid && !net_rx_busy`; head pops, `sent_count++`. Head data held stable while busy.
- Ejection: router transfer on edge with `net_tx_valid && !net_tx_busy`; flit written to ejection FIFO, `recv_count++`. `net_tx_busy = ej_full`.
- Core pop: `ej_valid = !ej_empty`, `ej_data` = head; pop on edge with `ej_valid && ej_ready`.
- Misroute: on ejection transfer, if `net_tx_data[ADDR_SZ-1:0] != id`, set `misroute`; flit still buffered.
- Watchdog: 8-bit-or-wider `stall_cnt` increments each cycle with `net_rx_valid && net_rx_busy`, clears otherwise; on reaching STALL_MAX set `stall`; counter saturates.
- Counters wrap modulo 2^16.

## Timing
- Reset: FIFOs empty; `inj_ready`=1, `net_rx_valid`=0, `net_tx_busy`=0, `ej_valid`=0, `net_rx_data`/`ej_data`=0, counters 0, `misroute`=0, `stall`=0. Reset mid-transfer discards all buffered flits.
- Inject latency: flit pushed at edge N → `net_rx_valid`=1 after edge N (no bypass when empty).
- Eject latency: flit accepted at edge N → `ej_valid`=1 after edge N.
- Full FIFO with simultaneous pop: ready/busy computed from current occupancy only, so no push that cycle; push accepted next cycle.
- Empty FIFO: pop requests ignored; simultaneous push+pop on non-full, non-empty FIFO keeps occupancy.
- `net_rx_valid` never deasserts without a transfer (no withdrawal).

## Structure
- Shared package: flit field widths/offsets, `FLIT_W`, direction index constants (`LOCAL`=4).
- Sub-module `ni_fifo` (sync, show-ahead, parameterised width/depth, full/empty, async reset), instantiated twice; counters, watchdog and misroute in top.

## Test plan
- Reset, push 3 flits addr=2 with `net_rx_busy`=0 → three `net_rx_valid` cycles, data in order, `sent_count`=3.
- `net_rx_busy`=1, push 5 flits (INJ_DEPTH=4) → `inj_ready`=0 after 4th; release busy → all 4 drain in order, 5th accepted after.
- Hold `net_rx_busy`=1 with valid for 255 cycles → `stall`=1 at cycle 255, stays 1 after busy drops.
- `id`=5, router sends 4 flits addr=5, `ej_ready`=0 → `net_tx_busy`=1 after 4th, `recv_count`=4; assert `ej_ready` → flits out in order, busy drops.
- Router sends flit addr=3 with `id`=5 → `misroute`=1, flit delivered on `ej_data`.
- Assert `reset` with both FIFOs half full → all outputs return to reset values same cycle; no stale flit after release.

Source files
------------

// File: rtl/local_port_ni_pkg.sv
// Shared definitions for the router local-port network interface:
// flit field geometry and router direction indices.
package local_port_ni_pkg;

  localparam int ADDR_SZ_DEF = 4;
  localparam int PL_SZ_DEF   = 16;
  localparam int HDR_SZ_DEF  = 2;

  // Flit layout, LSB first: destination, payload, header
  localparam int ADDR_OFF = 0;
  localparam int PL_OFF   = ADDR_SZ_DEF;
  localparam int HDR_OFF  = ADDR_SZ_DEF + PL_SZ_DEF;
  localparam int FLIT_W   = HDR_SZ_DEF + PL_SZ_DEF + ADDR_SZ_DEF;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    DIR_NORTH = 3'd0,
    DIR_EAST  = 3'd1,
    DIR_SOUTH = 3'd2,
    DIR_WEST  = 3'd3,
    DIR_LOCAL = 3'd4
  } dir_e;

  localparam int LOCAL = 4;

  function automatic int flitWidth(input int addrSz, input int plSz, input int hdrSz);
    return addrSz + plSz + hdrSz;
  endfunction

endpackage

// File: rtl/local_port_ni_fifo.sv
// Synchronous show-ahead FIFO used for both the injection and ejection paths.
// Push and pop are qualified here by full/empty, so callers may request freely.
module ni_fifo
  import local_port_ni_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = wr_en && !w_full;
  assign w_pop   = rd_en && !w_empty;

  assign full  = w_full;
  assign empty = w_empty;
  // Empty FIFO presents zero so stale storage never leaks onto the outputs
  assign rd_data = w_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= wr_data;
  end

endmodule

// File: rtl/local_port_ni.sv
// Router local-port network interface: buffered injection toward the router,
// buffered ejection toward the core, traffic counters, misroute flag and stall watchdog.
module local_port_ni
  import local_port_ni_pkg::*;
#(
  parameter int ADDR_SZ   = ADDR_SZ_DEF,
  parameter int PL_SZ     = PL_SZ_DEF,
  parameter int HDR_SZ    = HDR_SZ_DEF,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int STALL_MAX = 255,
  localparam int FW       = flitWidth(ADDR_SZ, PL_SZ, HDR_SZ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_SZ-1:0] id,
  input  logic               inj_valid,
  input  logic [FW-1:0]      inj_data,
  output logic               inj_ready,
  output logic [FW-1:0]      net_rx_data,
  output logic               net_rx_valid,
  input  logic               net_rx_busy,
  input  logic [FW-1:0]      net_tx_data,
  input  logic               net_tx_valid,
  output logic               net_tx_busy,
  output logic               ej_valid,
  output logic [FW-1:0]      ej_data,
  input  logic               ej_ready,
  output logic [CNT_W-1:0]   sent_count,
  output logic [CNT_W-1:0]   recv_count,
  output logic               misroute,
  output logic               stall
);

  localparam int STALL_W = ($clog2(STALL_MAX + 1) > 8) ? $clog2(STALL_MAX + 1) : 8;

  logic               w_injFull;
  logic               w_injEmpty;
  logic               w_ejFull;
  logic               w_ejEmpty;
  logic               w_sendXfer;
  logic               w_recvXfer;
  logic               w_stalling;
  logic [CNT_W-1:0]   r_sentCount;
  logic [CNT_W-1:0]   r_recvCount;
  logic               r_misroute;
  logic               r_stall;
  logic [STALL_W-1:0] r_stallCnt;

  assign inj_ready    = !w_injFull;
  assign net_rx_valid = !w_injEmpty;
  assign net_tx_busy  = w_ejFull;
  assign ej_valid     = !w_ejEmpty;

  assign w_sendXfer = !w_injEmpty && !net_rx_busy;
  assign w_recvXfer = net_tx_valid && !w_ejFull;
  assign w_stalling = !w_injEmpty && net_rx_busy;

  assign sent_count = r_sentCount;
  assign recv_count = r_recvCount;
  assign misroute   = r_misroute;
  assign stall      = r_stall;

  ni_fifo #(.WIDTH(FW), .DEPTH(INJ_DEPTH)) u_injFifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inj_valid),
    .wr_data (inj_data),
    .rd_en   (!net_rx_busy),
    .rd_data (net_rx_data),
    .full    (w_injFull),
    .empty   (w_injEmpty)
  );

  ni_fifo #(.WIDTH(FW), .DEPTH(EJ_DEPTH)) u_ejFifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (net_tx_valid),
    .wr_data (net_tx_data),
    .rd_en   (ej_ready),
    .rd_data (ej_data),
    .full    (w_ejFull),
    .empty   (w_ejEmpty)
  );

  // Misrouted flits are still buffered; the flag only records that one arrived
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sentCount <= '0;
      r_recvCount <= '0;
      r_misroute  <= 1'b0;
    end else begin
      if (w_sendXfer) r_sentCount <= r_sentCount + CNT_W'(1);
      if (w_recvXfer) begin
        r_recvCount <= r_recvCount + CNT_W'(1);
        if (net_tx_data[ADDR_SZ-1:0] != id) r_misroute <= 1'b1;
      end
    end
  end

  // Flag is raised on the edge the saturating counter reaches STALL_MAX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_stall    <= 1'b0;
    end else if (w_stalling) begin
      if (r_stallCnt != STALL_W'(STALL_MAX)) r_stallCnt <= r_stallCnt + STALL_W'(1);
      if (r_stallCnt >= STALL_W'(STALL_MAX - 1)) r_stall <= 1'b1;
    end else begin
      r_stallCnt <= '0;
    end
  end

endmodule

// File: tb/tb_local_port_ni.sv
// Randomised and directed checks of local_port_ni against a queue-based reference model.
module tb_local_port_ni;
  import local_port_ni_pkg::*;

  localparam int FW        = FLIT_W;
  localparam int INJ_DEPTH = 4;
  localparam int EJ_DEPTH  = 4;
  localparam int STALL_MAX = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    id;
  logic          inj_valid;
  logic [FW-1:0] inj_data;
  logic          inj_ready;
  logic [FW-1:0] net_rx_data;
  logic          net_rx_valid;
  logic          net_rx_busy;
  logic [FW-1:0] net_tx_data;
  logic          net_tx_valid;
  logic          net_tx_busy;
  logic          ej_valid;
  logic [FW-1:0] ej_data;
  logic          ej_ready;
  logic [15:0]   sent_count;
  logic [15:0]   recv_count;
  logic          misroute;
  logic          stall;

  always #5 clk = ~clk;

  local_port_ni #(
    .INJ_DEPTH (INJ_DEPTH),
    .EJ_DEPTH  (EJ_DEPTH),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id           (id),
    .inj_valid    (inj_valid),
    .inj_data     (inj_data),
    .inj_ready    (inj_ready),
    .net_rx_data  (net_rx_data),
    .net_rx_valid (net_rx_valid),
    .net_rx_busy  (net_rx_busy),
    .net_tx_data  (net_tx_data),
    .net_tx_valid (net_tx_valid),
    .net_tx_busy  (net_tx_busy),
    .ej_valid     (ej_valid),
    .ej_data      (ej_data),
    .ej_ready     (ej_ready),
    .sent_count   (sent_count),
    .recv_count   (recv_count),
    .misroute     (misroute),
    .stall        (stall)
  );

  // Reference model: the two buffers as queues plus plain counters
  logic [FW-1:0] injQ[$];
  logic [FW-1:0] ejQ[$];
  logic [15:0]   mSent;
  logic [15:0]   mRecv;
  logic          mMis;
  logic          mStall;
  int            mStallRun;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [FW-1:0] mkFlit(input logic [1:0] h, input logic [15:0] p,
                                           input logic [3:0] a);
    return {h, p, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    injQ.delete();
    ejQ.delete();
    mSent     = '0;
    mRecv     = '0;
    mMis      = 1'b0;
    mStall    = 1'b0;
    mStallRun = 0;
  endtask

  task automatic checkAll();
    logic [FW-1:0] injHead;
    logic [FW-1:0] ejHead;
    injHead = (injQ.size() > 0) ? injQ[0] : '0;
    ejHead  = (ejQ.size() > 0) ? ejQ[0] : '0;
    checkOutput("inj_ready",    32'(inj_ready),    32'(injQ.size() < INJ_DEPTH));
    checkOutput("net_rx_valid", 32'(net_rx_valid), 32'(injQ.size() > 0));
    checkOutput("net_rx_data",  32'(net_rx_data),  32'(injHead));
    checkOutput("net_tx_busy",  32'(net_tx_busy),  32'(ejQ.size() >= EJ_DEPTH));
    checkOutput("ej_valid",     32'(ej_valid),     32'(ejQ.size() > 0));
    checkOutput("ej_data",      32'(ej_data),      32'(ejHead));
    checkOutput("sent_count",   32'(sent_count),   32'(mSent));
    checkOutput("recv_count",   32'(recv_count),   32'(mRecv));
    checkOutput("misroute",     32'(misroute),     32'(mMis));
    checkOutput("stall",        32'(stall),        32'(mStall));
  endtask

  // One clock: check the state left by the last edge, drive inputs, advance the model
  task automatic applyStimulus(input logic [3:0] nodeId, input logic iv, input logic [FW-1:0] idat,
                               input logic busy, input logic tv, input logic [FW-1:0] tdat,
                               input logic er);
    bit canPush;
    bit canSend;
    bit canAccept;
    bit canDeliver;
    @(negedge clk);
    checkAll();
    id           = nodeId;
    inj_valid    = iv;
    inj_data     = idat;
    net_rx_busy  = busy;
    net_tx_valid = tv;
    net_tx_data  = tdat;
    ej_ready     = er;
    canPush    = injQ.size() < INJ_DEPTH;
    canSend    = (injQ.size() > 0) && !busy;
    canAccept  = tv && (ejQ.size() < EJ_DEPTH);
    canDeliver = (ejQ.size() > 0) && er;
    if ((injQ.size() > 0) && busy) begin
      mStallRun = (mStallRun < STALL_MAX) ? mStallRun + 1 : STALL_MAX;
      if (mStallRun >= STALL_MAX) mStall = 1'b1;
    end else begin
      mStallRun = 0;
    end
    if (canSend) begin
      void'(injQ.pop_front());
      mSent++;
    end
    if (iv && canPush) injQ.push_back(idat);
    if (canDeliver) void'(ejQ.pop_front());
    if (canAccept) begin
      ejQ.push_back(tdat);
      mRecv++;
      if (tdat[3:0] != nodeId) mMis = 1'b1;
    end
  endtask

  task automatic idle(input logic [3:0] nodeId, input logic busy, input logic er, input int n);
    for (int i = 0; i < n; i++) applyStimulus(nodeId, 1'b0, '0, busy, 1'b0, '0, er);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock
  task automatic doReset();
    @(negedge clk);
    inj_valid    = 1'b0;
    net_tx_valid = 1'b0;
    ej_ready     = 1'b0;
    net_rx_busy  = 1'b0;
    reset        = 1'b1;
    modelClear();
    #1;
    checkAll();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] rid;
    reset = 1'b1;
    id = '0; inj_valid = 1'b0; inj_data = '0; net_rx_busy = 1'b0;
    net_tx_valid = 1'b0; net_tx_data = '0; ej_ready = 1'b0;
    modelClear();
    repeat (2) @(negedge clk);
    checkAll();
    reset = 1'b0;

    // Three flits to address 2 drain straight through
    for (int i = 0; i < 3; i++)
      applyStimulus(4'd2, 1'b1, mkFlit(2'd1, 16'h100 + 16'(i), 4'd2), 1'b0, 1'b0, '0, 1'b0);
    idle(4'd2, 1'b0, 1'b0, 4);

    // Fill injection FIFO against backpressure, then release
    for (int i = 0; i < 5; i++)
      applyStimulus(4'd2, 1'b1, mkFlit(2'd2, 16'h200 + 16'(i), 4'd2), 1'b1, 1'b0, '0, 1'b0);
    idle(4'd2, 1'b1, 1'b0, 2);
    for (int i = 0; i < 2; i++)
      applyStimulus(4'd2, 1'b1, mkFlit(2'd2, 16'h2FF, 4'd2), 1'b0, 1'b0, '0, 1'b0);
    idle(4'd2, 1'b0, 1'b0, 7);

    // Watchdog: one flit held back well past the threshold
    applyStimulus(4'd2, 1'b1, mkFlit(2'd3, 16'h300, 4'd2), 1'b1, 1'b0, '0, 1'b0);
    idle(4'd2, 1'b1, 1'b0, STALL_MAX + 3);
    idle(4'd2, 1'b0, 1'b0, 4);

    // Ejection backpressure with id=5, then misrouted flit for address 3
    for (int i = 0; i < 5; i++)
      applyStimulus(4'd5, 1'b0, '0, 1'b0, 1'b1, mkFlit(2'd0, 16'h500 + 16'(i), 4'd5), 1'b0);
    idle(4'd5, 1'b0, 1'b0, 2);
    idle(4'd5, 1'b0, 1'b1, 6);
    applyStimulus(4'd5, 1'b0, '0, 1'b0, 1'b1, mkFlit(2'd1, 16'h5A5, 4'd3), 1'b0);
    idle(4'd5, 1'b0, 1'b1, 3);

    // Both FIFOs half full, then reset
    for (int i = 0; i < 2; i++)
      applyStimulus(4'd5, 1'b1, mkFlit(2'd0, 16'h600 + 16'(i), 4'd1), 1'b1,
                    1'b1, mkFlit(2'd0, 16'h700 + 16'(i), 4'd5), 1'b0);
    doReset();
    idle(4'd5, 1'b0, 1'b1, 4);

    // Randomised traffic with varying pressure on both sides
    rid = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      int busyPct;
      int readyPct;
      logic [3:0] taddr;
      if (c % 500 == 0) rid = 4'($urandom_range(0, 15));
      if (c == 1700) doReset();
      busyPct  = ((c / 250) % 2 == 0) ? 30 : 80;
      readyPct = ((c / 300) % 2 == 0) ? 70 : 20;
      taddr    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : rid;
      applyStimulus(rid,
                    1'($urandom_range(0, 99) < 60),
                    FW'($urandom),
                    1'($urandom_range(0, 99) < busyPct),
                    1'($urandom_range(0, 99) < 50),
                    {FW-4'($urandom), taddr} ,
                    1'($urandom_range(0, 99) < readyPct));
    end
    idle(rid, 1'b0, 1'b1, 8);
    @(negedge clk);
    checkAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
